// File: rtl/rs_pkg.sv
// Shared types and constants for the add/sub reservation station.
package rs_pkg;

    localparam int unsigned DATA_W  = 12;
    localparam int unsigned TAG_W   = 3;
    localparam int unsigned LABEL_W = 2;
    localparam int unsigned NUM_RS  = 3;
    localparam int unsigned OP_W    = 3;
    localparam int unsigned AGE_W   = 2;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;

    typedef enum logic {
        IDLE,
        EXEC
    } rs_state_e;

    // age: 0 = oldest busy entry; ages of busy entries are always distinct
    typedef struct packed {
        logic              busy;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] vj;
        logic [DATA_W-1:0] vk;
        logic [TAG_W-1:0]  qj;
        logic [TAG_W-1:0]  qk;
        logic              exec;
        logic [AGE_W-1:0]  age;
    } rs_entry_t;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/rs_addsub_select.sv
// Oldest-ready picker: returns the ready entry with the smallest age.
module rs_addsub_select
    import rs_pkg::*;
(
    input  logic [NUM_RS-1:0]       ready_i,
    input  logic [NUM_RS*AGE_W-1:0] age_i,
    output logic [LABEL_W-1:0]      idx_o,
    output logic                    found_o
);

    logic [AGE_W-1:0]   best_age;
    logic [LABEL_W-1:0] best_idx;
    logic               found;

    always_comb begin
        best_age = '1;
        best_idx = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < NUM_RS; i++) begin
            if (ready_i[i] && (!found || (age_i[i*AGE_W +: AGE_W] < best_age))) begin
                found    = 1'b1;
                best_idx = LABEL_W'(i);
                best_age = age_i[i*AGE_W +: AGE_W];
            end
        end
        idx_o   = best_idx;
        found_o = found;
    end

endmodule

// File: rtl/rs_addsub.sv
// Three-entry reservation station feeding a single add/sub unit.
// Optional macro RS_ADDSUB_CDB_BYPASS_EN: capture a same-cycle CDB broadcast at issue.
module rs_addsub
    import rs_pkg::*;
#(
    parameter logic [TAG_W-1:0] TAG_BASE = 3'd1
) (
    input  logic               Clock,
    input  logic               Resetn,
    input  logic               issue_valid,
    output logic               issue_ready,
    input  logic [OP_W-1:0]    issue_op,
    input  logic [DATA_W-1:0]  issue_vj,
    input  logic [DATA_W-1:0]  issue_vk,
    input  logic [TAG_W-1:0]   issue_qj,
    input  logic [TAG_W-1:0]   issue_qk,
    output logic [TAG_W-1:0]   issue_tag,
    output logic               illegal_op,
    input  logic               cdb_valid,
    input  logic [TAG_W-1:0]   cdb_tag,
    input  logic [DATA_W-1:0]  cdb_data,
    output logic               fu_en,
    output logic [DATA_W-1:0]  fu_rx,
    output logic [DATA_W-1:0]  fu_ry,
    output logic [OP_W-1:0]    fu_op,
    output logic [LABEL_W-1:0] fu_label,
    input  logic               fu_done,
    input  logic [LABEL_W-1:0] fu_label_in,
    input  logic [DATA_W-1:0]  fu_out,
    output logic               result_valid,
    output logic [TAG_W-1:0]   result_tag,
    output logic [DATA_W-1:0]  result_data
);

    rs_entry_t [NUM_RS-1:0] ent_q, ent_d;
    rs_state_e              state_q, state_d;
    logic [LABEL_W-1:0]     exec_idx_q, exec_idx_d;
    logic [DATA_W-1:0]      fu_rx_q, fu_rx_d, fu_ry_q, fu_ry_d;
    logic [OP_W-1:0]        fu_op_q, fu_op_d;
    logic                   illegal_q, illegal_d;
    logic                   res_valid_q, res_valid_d;
    logic [TAG_W-1:0]       res_tag_q, res_tag_d;
    logic [DATA_W-1:0]      res_data_q, res_data_d;

    logic                   any_free;
    logic [LABEL_W-1:0]     free_idx;
    logic [AGE_W-1:0]       n_busy;
    logic [AGE_W-1:0]       alloc_age;
    logic                   xfer, alloc, complete, dispatch;
    logic [DATA_W-1:0]      new_vj, new_vk;
    logic [TAG_W-1:0]       new_qj, new_qk;
    logic [NUM_RS-1:0]      ready_vec;
    logic [NUM_RS*AGE_W-1:0] age_vec;
    logic [LABEL_W-1:0]     sel_idx;
    logic                   sel_found;

    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        n_busy   = '0;
        for (int unsigned i = NUM_RS; i > 0; i--) begin
            if (!ent_q[i-1].busy) begin
                any_free = 1'b1;
                free_idx = LABEL_W'(i-1);
            end
            n_busy = n_busy + AGE_W'(ent_q[i-1].busy);
        end
    end

    always_comb begin
        new_vj = issue_vj;
        new_vk = issue_vk;
        new_qj = issue_qj;
        new_qk = issue_qk;
`ifdef RS_ADDSUB_CDB_BYPASS_EN
        issue_ready = any_free;
        if (cdb_valid && (issue_qj != '0) && (issue_qj == cdb_tag)) begin
            new_vj = cdb_data;
            new_qj = '0;
        end
        if (cdb_valid && (issue_qk != '0) && (issue_qk == cdb_tag)) begin
            new_vk = cdb_data;
            new_qk = '0;
        end
`else
        issue_ready = any_free && !cdb_valid;
`endif
    end

    assign xfer      = issue_valid && issue_ready;
    assign alloc     = xfer && op_is_legal(issue_op);
    assign illegal_d = xfer && !op_is_legal(issue_op);
    assign issue_tag = alloc ? (TAG_BASE + TAG_W'(free_idx)) : '0;
    assign complete  = (state_q == EXEC) && fu_done && (fu_label_in == exec_idx_q);
    assign alloc_age = n_busy - AGE_W'(complete);

    // A fully-resolved issue joins the ready set in its allocation cycle so an
    // idle unit can start on it immediately; it is always the youngest.
    always_comb begin
        for (int unsigned i = 0; i < NUM_RS; i++) begin
            ready_vec[i] = ent_q[i].busy && !ent_q[i].exec &&
                           (ent_q[i].qj == '0) && (ent_q[i].qk == '0);
            age_vec[i*AGE_W +: AGE_W] = ent_q[i].age;
            if (alloc && (free_idx == LABEL_W'(i)) && (new_qj == '0) && (new_qk == '0)) begin
                ready_vec[i] = 1'b1;
                age_vec[i*AGE_W +: AGE_W] = alloc_age;
            end
        end
    end

    rs_addsub_select u_select (
        .ready_i (ready_vec),
        .age_i   (age_vec),
        .idx_o   (sel_idx),
        .found_o (sel_found)
    );

    assign dispatch = (state_q == IDLE) && !res_valid_q && sel_found;

    always_comb begin
        ent_d = ent_q;
        for (int unsigned i = 0; i < NUM_RS; i++) begin
            if (ent_q[i].busy && cdb_valid) begin
                if ((ent_q[i].qj != '0) && (ent_q[i].qj == cdb_tag)) begin
                    ent_d[i].vj = cdb_data;
                    ent_d[i].qj = '0;
                end
                if ((ent_q[i].qk != '0) && (ent_q[i].qk == cdb_tag)) begin
                    ent_d[i].vk = cdb_data;
                    ent_d[i].qk = '0;
                end
            end
            if (complete && (exec_idx_q == LABEL_W'(i))) begin
                ent_d[i] = '0;
            end else if (complete && ent_q[i].busy && (ent_q[i].age > ent_q[exec_idx_q].age)) begin
                ent_d[i].age = ent_q[i].age - 1'b1;
            end
            if (alloc && (free_idx == LABEL_W'(i))) begin
                ent_d[i].busy = 1'b1;
                ent_d[i].op   = issue_op;
                ent_d[i].vj   = new_vj;
                ent_d[i].vk   = new_vk;
                ent_d[i].qj   = new_qj;
                ent_d[i].qk   = new_qk;
                ent_d[i].exec = 1'b0;
                ent_d[i].age  = alloc_age;
            end
            if (dispatch && (sel_idx == LABEL_W'(i))) begin
                ent_d[i].exec = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        exec_idx_d  = exec_idx_q;
        fu_rx_d     = fu_rx_q;
        fu_ry_d     = fu_ry_q;
        fu_op_d     = fu_op_q;
        res_valid_d = 1'b0;
        res_tag_d   = '0;
        res_data_d  = '0;
        case (state_q)
            IDLE: begin
                if (dispatch) begin
                    state_d    = EXEC;
                    exec_idx_d = sel_idx;
                    fu_rx_d    = ent_d[sel_idx].vj;
                    fu_ry_d    = ent_d[sel_idx].vk;
                    fu_op_d    = ent_d[sel_idx].op;
                end
            end
            EXEC: begin
                if (complete) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b1;
                    res_tag_d   = TAG_BASE + TAG_W'(exec_idx_q);
                    res_data_d  = fu_out;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            ent_q       <= '0;
            state_q     <= IDLE;
            exec_idx_q  <= '0;
            fu_rx_q     <= '0;
            fu_ry_q     <= '0;
            fu_op_q     <= '0;
            illegal_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_tag_q   <= '0;
            res_data_q  <= '0;
        end else begin
            ent_q       <= ent_d;
            state_q     <= state_d;
            exec_idx_q  <= exec_idx_d;
            fu_rx_q     <= fu_rx_d;
            fu_ry_q     <= fu_ry_d;
            fu_op_q     <= fu_op_d;
            illegal_q   <= illegal_d;
            res_valid_q <= res_valid_d;
            res_tag_q   <= res_tag_d;
            res_data_q  <= res_data_d;
        end
    end

    assign fu_en        = (state_q == EXEC);
    assign fu_rx        = fu_rx_q;
    assign fu_ry        = fu_ry_q;
    assign fu_op        = fu_op_q;
    assign fu_label     = exec_idx_q;
    assign illegal_op   = illegal_q;
    assign result_valid = res_valid_q;
    assign result_tag   = res_tag_q;
    assign result_data  = res_data_q;

endmodule
